// File: rtl/nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
//   Sequencing controller for one NCO instance. Steps the NCO phase increment
//   from a start value towards a stop value, holding each step for a
//   programmable dwell. Each NCO output sample is tagged with the step it
//   belongs to, so capture logic can drop samples still in the NCO pipeline
//   from the previous step.
//
//   Parameters
//     APR      phase-increment width
//     DW       dwell counter width
//     SW       step-index width
//     NCO_LAT  NCO latency in clken cycles
//
//   Ports
//     clk, reset_n            clock, async active-low reset
//     start, abort, pause     sweep control (abort > pause > start)
//     cfg_start_inc/stop_inc  sweep bounds, latched at start
//     cfg_step, cfg_dwell     step size (0 = single step), dwell (0 = 1)
//     nco_out_valid           NCO out_valid
//     nco_phi_inc, nco_clken  NCO drive
//     busy, done, aborted     status (done/aborted are one-cycle pulses)
//     step_idx                step currently being driven
//     samp_valid, samp_idx    tag of the NCO output sample in this cycle
//
//   Build option
//     NCO_SWEEP_BIDIR_EN  when defined, the sweep turns round at the top and
//                         steps back down to the start value before flushing.
// -----------------------------------------------------------------------------
module nco_sweep_ctrl #(
  parameter int APR     = 8,
  parameter int DW      = 16,
  parameter int SW      = 8,
  parameter int NCO_LAT = 9
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic           pause,
  input  logic [APR-1:0] cfg_start_inc,
  input  logic [APR-1:0] cfg_stop_inc,
  input  logic [APR-1:0] cfg_step,
  input  logic [DW-1:0]  cfg_dwell,
  input  logic           nco_out_valid,
  output logic [APR-1:0] nco_phi_inc,
  output logic           nco_clken,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic [SW-1:0]  step_idx,
  output logic           samp_valid,
  output logic [SW-1:0]  samp_idx
);

  localparam int              FW         = (NCO_LAT > 1) ? $clog2(NCO_LAT) : 1;
  localparam logic [FW-1:0]   FLUSH_LOAD = FW'(NCO_LAT - 1);
  localparam logic [FW-1:0]   FLUSH_ONE  = FW'(1);
  localparam logic [DW-1:0]   DWELL_ONE  = DW'(1);
  localparam logic [SW-1:0]   IDX_ONE    = SW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [APR-1:0]             phi_q, phi_d;
  logic [SW-1:0]              idx_q, idx_d;
  logic [DW-1:0]              dwell_cnt_q, dwell_cnt_d;
  logic [FW-1:0]              flush_cnt_q, flush_cnt_d;
  logic [APR-1:0]             stop_q, stop_d;
  logic [APR-1:0]             step_q, step_d;
  logic [DW-1:0]              dwell_q, dwell_d;
  logic                       done_q, done_d;
  logic                       aborted_q, aborted_d;
  logic                       busy_q;
  // Tag delay line: bit SW is "issued during RUN", low bits are the step index.
  logic [NCO_LAT-1:0][SW:0]   dl_q, dl_d;
`ifdef NCO_SWEEP_BIDIR_EN
  logic                       dir_q, dir_d;      // 1 = stepping down
  logic [APR-1:0]             start_q, start_d;
  logic [APR:0]               nxt_dn_s;
  logic                       dn_end_s;
`endif

  logic                       clken_s;
  logic [APR:0]               nxt_up_s;
  logic                       up_end_s;
  logic [DW-1:0]              dwell_load_s;

  // Any active state runs the NCO unless paused; pause freezes everything.
  assign clken_s      = (state_q != S_IDLE) & ~pause;
  assign nxt_up_s     = {1'b0, phi_q} + {1'b0, step_q};
  assign up_end_s     = nxt_up_s[APR] | (nxt_up_s[APR-1:0] > stop_q) | (step_q == {APR{1'b0}});
  // Dwell 0 behaves as dwell 1; the counter runs down to zero inclusive.
  assign dwell_load_s = (dwell_q == {DW{1'b0}}) ? {DW{1'b0}} : (dwell_q - DWELL_ONE);
`ifdef NCO_SWEEP_BIDIR_EN
  assign nxt_dn_s     = {1'b0, phi_q} - {1'b0, step_q};
  assign dn_end_s     = nxt_dn_s[APR] | (nxt_dn_s[APR-1:0] < start_q) | (step_q == {APR{1'b0}});
`endif

  // Next-state, counter, tag delay-line and status-pulse logic.
  always_comb begin
    state_d     = state_q;
    phi_d       = phi_q;
    idx_d       = idx_q;
    dwell_cnt_d = dwell_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    dl_d        = dl_q;
`ifdef NCO_SWEEP_BIDIR_EN
    dir_d       = dir_q;
    start_d     = start_q;
`endif
    if (abort) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
      dl_d      = {(NCO_LAT * (SW + 1)){1'b0}};
    end else if (clken_s) begin
      for (int i = NCO_LAT - 1; i > 0; i--) begin
        dl_d[i] = dl_q[i-1];
      end
      dl_d[0] = {(state_q == S_RUN), idx_q};
      case (state_q)
        S_PRIME: begin
          if (nco_out_valid) begin
            state_d     = S_RUN;
            dwell_cnt_d = dwell_load_s;
          end else begin
            state_d = S_PRIME;
          end
        end
        S_RUN: begin
          if (dwell_cnt_q == {DW{1'b0}}) begin
            dwell_cnt_d = dwell_load_s;
`ifdef NCO_SWEEP_BIDIR_EN
            if (!dir_q && !up_end_s) begin
              phi_d = nxt_up_s[APR-1:0];
              idx_d = idx_q + IDX_ONE;
            end else if (!dn_end_s) begin
              // Turn-round step is taken immediately from the top value.
              dir_d = 1'b1;
              phi_d = nxt_dn_s[APR-1:0];
              idx_d = idx_q + IDX_ONE;
            end else begin
              state_d     = S_FLUSH;
              flush_cnt_d = FLUSH_LOAD;
            end
`else
            if (!up_end_s) begin
              phi_d = nxt_up_s[APR-1:0];
              idx_d = idx_q + IDX_ONE;
            end else begin
              state_d     = S_FLUSH;
              flush_cnt_d = FLUSH_LOAD;
            end
`endif
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == {FW{1'b0}}) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if ((state_q == S_IDLE) && start) begin
      state_d = S_PRIME;
      phi_d   = cfg_start_inc;
      idx_d   = {SW{1'b0}};
      stop_d  = cfg_stop_inc;
      step_d  = cfg_step;
      dwell_d = cfg_dwell;
`ifdef NCO_SWEEP_BIDIR_EN
      dir_d   = 1'b0;
      start_d = cfg_start_inc;
`endif
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      phi_q       <= {APR{1'b0}};
      idx_q       <= {SW{1'b0}};
      dwell_cnt_q <= {DW{1'b0}};
      flush_cnt_q <= {FW{1'b0}};
      stop_q      <= {APR{1'b0}};
      step_q      <= {APR{1'b0}};
      dwell_q     <= {DW{1'b0}};
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
      dl_q        <= {(NCO_LAT * (SW + 1)){1'b0}};
`ifdef NCO_SWEEP_BIDIR_EN
      dir_q       <= 1'b0;
      start_q     <= {APR{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      phi_q       <= phi_d;
      idx_q       <= idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      busy_q      <= (state_d != S_IDLE);
      dl_q        <= dl_d;
`ifdef NCO_SWEEP_BIDIR_EN
      dir_q       <= dir_d;
      start_q     <= start_d;
`endif
    end
  end

  assign nco_phi_inc = phi_q;
  assign nco_clken   = clken_s;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign step_idx    = idx_q;
  assign samp_idx    = dl_q[NCO_LAT-1][SW-1:0];
  assign samp_valid  = dl_q[NCO_LAT-1][SW] & nco_out_valid & clken_s;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
module tb_nco_sweep_ctrl;
  localparam int APR = 8;
  localparam int DW  = 16;
  localparam int SW  = 8;
  localparam int LAT = 9;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0, abort = 1'b0, pause = 1'b0, nco_out_valid = 1'b0;
  logic [APR-1:0] cfg_start_inc = '0, cfg_stop_inc = '0, cfg_step = '0;
  logic [DW-1:0]  cfg_dwell = '0;
  logic [APR-1:0] nco_phi_inc;
  logic           nco_clken, busy, done, aborted, samp_valid;
  logic [SW-1:0]  step_idx, samp_idx;

  nco_sweep_ctrl #(.APR(APR), .DW(DW), .SW(SW), .NCO_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .pause(pause),
    .cfg_start_inc(cfg_start_inc), .cfg_stop_inc(cfg_stop_inc), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .nco_out_valid(nco_out_valid), .nco_phi_inc(nco_phi_inc),
    .nco_clken(nco_clken), .busy(busy), .done(done), .aborted(aborted),
    .step_idx(step_idx), .samp_valid(samp_valid), .samp_idx(samp_idx));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a sweep is a list of increments; after priming, a
  // timeline of clken cycles t = 0 .. N*D-1 drives steps[t/D], then LAT
  // flush cycles, then done. Sample tags are an LAT-deep history of clken cycles.
  bit m_busy, m_primed, m_done, m_aborted;
  int m_phi, m_idx, m_t, m_dw, m_n, nv_cnt;
  int steps[$];
  bit hv[LAT];
  int hi[LAT];

  // Per-scenario statistics observed on the DUT.
  int n_samp, n_done, n_abort, n_busy, clk_idx1;
  int samp_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void build_steps(int s, int e, int st);
    int v;
    steps.delete();
    v = s;
    steps.push_back(v);
    if (st != 0) begin
      while (v + st <= e && v + st <= 255) begin v += st; steps.push_back(v); end
`ifdef NCO_SWEEP_BIDIR_EN
      while (v - st >= s) begin v -= st; steps.push_back(v); end
`endif
    end
  endfunction

  task automatic model_reset();
    m_busy = 0; m_primed = 0; m_done = 0; m_aborted = 0;
    m_phi = 0; m_idx = 0; m_t = 0; nv_cnt = 0;
    for (int i = 0; i < LAT; i++) begin hv[i] = 0; hi[i] = 0; end
  endtask

  task automatic clr_stats();
    n_samp = 0; n_done = 0; n_abort = 0; n_busy = 0; clk_idx1 = 0;
    samp_log.delete();
  endtask

  // Called at a falling edge with this cycle's inputs applied: compare, then
  // advance the model across the coming rising edge.
  task automatic tick();
    bit ck, exp_sv;
    nco_out_valid = (nv_cnt >= LAT);
    #1;
    ck = m_busy && !pause;
    exp_sv = hv[LAT-1] && nco_out_valid && ck;
    chk("busy", busy, m_busy);
    chk("clken", nco_clken, ck);
    chk("done", done, m_done);
    chk("aborted", aborted, m_aborted);
    chk("phi_inc", nco_phi_inc, m_phi);
    chk("step_idx", step_idx, m_idx);
    chk("samp_valid", samp_valid, exp_sv);
    chk("samp_idx", samp_idx, hi[LAT-1]);
    if (samp_valid) begin n_samp++; samp_log.push_back(int'(samp_idx)); end
    if (done) n_done++;
    if (aborted) n_abort++;
    if (busy) n_busy++;
    if (busy && nco_clken && step_idx == 8'd1) clk_idx1++;
    m_done = 0; m_aborted = 0;
    if (ck) nv_cnt++;
    if (abort) begin
      m_aborted = 1; m_busy = 0;
      for (int i = 0; i < LAT; i++) begin hv[i] = 0; hi[i] = 0; end
    end else if (ck) begin
      for (int i = LAT - 1; i > 0; i--) begin hv[i] = hv[i-1]; hi[i] = hi[i-1]; end
      hv[0] = m_primed && (m_t < m_n * m_dw);
      hi[0] = m_idx;
      if (!m_primed) begin
        if (nco_out_valid) begin m_primed = 1; m_t = 0; end
      end else begin
        m_t++;
        if (m_t < m_n * m_dw) begin
          m_phi = steps[m_t / m_dw];
          m_idx = (m_t / m_dw) % 256;
        end else if (m_t == m_n * m_dw + LAT) begin
          m_busy = 0; m_done = 1;
        end
      end
    end else if (!m_busy && start) begin
      build_steps(int'(cfg_start_inc), int'(cfg_stop_inc), int'(cfg_step));
      m_n = steps.size();
      m_dw = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
      m_busy = 1; m_primed = 0; m_phi = steps[0]; m_idx = 0;
    end
    @(negedge clk);
  endtask

  task automatic run_to_idle(int budget);
    int c = 0;
    while ((m_busy || busy) && c < budget) begin tick(); c++; end
    checks++;
    if (c >= budget) begin errors++; $display("FAIL timeout: got busy %0d expected 0", busy); end
    tick();
  endtask

  task automatic launch(int s, int e, int st, int dw);
    cfg_start_inc = APR'(s); cfg_stop_inc = APR'(e); cfg_step = APR'(st); cfg_dwell = DW'(dw);
    clr_stats();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_idx(int idx);
    int c = 0;
    while (int'(step_idx) != idx && c < 300) begin tick(); c++; end
    checks++;
    if (c >= 300) begin errors++; $display("FAIL wait_idx: got %0d expected %0d", step_idx, idx); end
  endtask

  initial begin
    model_reset();
    clr_stats();
    repeat (2) @(negedge clk);
    chk("rst_phi", nco_phi_inc, 0); chk("rst_clken", nco_clken, 0);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0); chk("rst_step_idx", step_idx, 0);
    chk("rst_samp_valid", samp_valid, 0); chk("rst_samp_idx", samp_idx, 0);
    reset_n = 1;
    repeat (2) tick();

    // Pin the model against hand-computed sweeps.
    build_steps(10, 40, 10);
    chk("pin_basic_n", steps.size(), 4); chk("pin_basic_last", steps[3], 40);
    build_steps(250, 255, 4);
    chk("pin_ovf_n", steps.size(), 2); chk("pin_ovf_last", steps[1], 254);
`ifdef NCO_SWEEP_BIDIR_EN
    build_steps(10, 30, 10);
    chk("pin_bidir_n", steps.size(), 5); chk("pin_bidir_3", steps[3], 20);
`endif

    // Basic sweep: 10 PRIME (NCO filling) + 16 RUN + 9 FLUSH busy cycles.
    launch(10, 40, 10, 4);
    run_to_idle(200);
    chk("basic_busy_cycles", n_busy, 35);
    chk("basic_done", n_done, 1);
    chk("basic_samples", n_samp, 16);
    for (int i = 0; i < 16 && i < samp_log.size(); i++) chk("basic_samp_idx", samp_log[i], i / 4);

    // Overflow with dwell 0: 250, 254, then 258 carries.
    launch(250, 255, 4, 0);
    run_to_idle(200);
    chk("ovf_busy_cycles", n_busy, 12);
    chk("ovf_samples", n_samp, 2);

    // Pause mid-step: step 1 still receives exactly 8 clken cycles.
    launch(10, 40, 10, 8);
    wait_idx(1);
    repeat (3) tick();
    pause = 1; repeat (5) tick(); pause = 0;
    run_to_idle(300);
    chk("pause_step1_clken", clk_idx1, 8);
    chk("pause_samples", n_samp, 32);

    // Abort during step 2.
    launch(10, 40, 10, 4);
    wait_idx(2);
    tick();
    abort = 1; tick(); abort = 0;
    repeat (12) tick();
    chk("abort_done", n_done, 0); chk("abort_pulses", n_abort, 1); chk("abort_busy", busy, 0);

    // Abort and start together in IDLE.
    cfg_start_inc = 8'd5; cfg_stop_inc = 8'd50; cfg_step = 8'd5; cfg_dwell = 16'd2;
    clr_stats();
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    repeat (4) tick();
    chk("abst_busy", n_busy, 0); chk("abst_pulses", n_abort, 1);

`ifdef NCO_SWEEP_BIDIR_EN
    launch(10, 30, 10, 1);
    run_to_idle(200);
    chk("bidir_samples", n_samp, 5);
    for (int i = 0; i < 5 && i < samp_log.size(); i++) chk("bidir_samp_idx", samp_log[i], i);
`endif

    // Asynchronous reset mid-sweep.
    launch(0, 200, 1, 3);
    repeat (30) tick();
    #2 reset_n = 0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_clken", nco_clken, 0);
    chk("arst_phi", nco_phi_inc, 0); chk("arst_step_idx", step_idx, 0);
    chk("arst_samp_valid", samp_valid, 0); chk("arst_samp_idx", samp_idx, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    repeat (3) tick();

    // Randomised sweeps with config churn, pause and rare abort.
    for (int s = 0; s < 25; s++) begin
      int c;
      launch($urandom_range(0, 255), $urandom_range(0, 255),
             ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40), $urandom_range(0, 4));
      c = 0;
      while ((m_busy || busy) && c < 4000) begin
        pause = ($urandom_range(0, 99) < 15);
        abort = ($urandom_range(0, 299) == 0);
        start = ($urandom_range(0, 9) == 0);
        cfg_start_inc = APR'($urandom); cfg_stop_inc = APR'($urandom);
        cfg_step = APR'($urandom); cfg_dwell = DW'($urandom_range(0, 6));
        tick();
        c++;
      end
      pause = 0; abort = 0; start = 0;
      checks++;
      if (c >= 4000) begin errors++; $display("FAIL rand_timeout: got busy %0d expected 0", busy); end
      repeat (2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Sequencing controller for the NCO core in the CORDIC/NCO datapath. It owns the NCO's `phi_inc_i` and `clken` inputs and steps the phase increment from a start value to a stop value, holding each step for a programmable dwell. It tags every NCO output sample with the step it belongs to, so downstream capture logic can discard the samples that are still in the NCO pipeline from the previous step. It sits between the register/control interface and one NCO instance.

## Interface
Parameters:
- `APR`, 8, phase-increment width (matches NCO `apr`)
- `DW`, 16, dwell counter width
- `SW`, 8, step-index width
- `NCO_LAT`, 9, NCO latency in clken cycles from `phi_inc_i` to `fsin_o`/`fcos_o`

Ports:
- `clk` in 1, single clock
- `reset_n` in 1, asynchronous active-low reset
- `start` in 1, begin sweep; sampled only in IDLE
- `abort` in 1, terminate sweep from any state
- `pause` in 1, freeze sweep
- `cfg_start_inc` in APR, first phase increment
- `cfg_stop_inc` in APR, last allowed phase increment
- `cfg_step` in APR, increment step; 0 means a single step
- `cfg_dwell` in DW, clken cycles per step; 0 is treated as 1
- `nco_out_valid` in 1, NCO `out_valid`
- `nco_phi_inc` out APR, drives NCO `phi_inc_i`
- `nco_clken` out 1, drives NCO `clken`
- `busy` out 1, high in any state except IDLE
- `done` out 1, one-cycle pulse at normal completion
- `aborted` out 1, one-cycle pulse on abort
- `step_idx` out SW, index of the step currently being driven
- `samp_valid` out 1, current NCO output belongs to a settled in-sweep step
- `samp_idx` out SW, step index of the current NCO output

## Operation
- The `cfg_*` inputs are latched at `start`; later changes are ignored until the next start.

State machine: IDLE → PRIME → RUN → FLUSH → IDLE.
- **IDLE**: `nco_clken`=0. When `start`=1, latch cfg, load `nco_phi_inc`=`cfg_start_inc`, set `step_idx`=0, go to PRIME.
- **PRIME**: `nco_clken`=1. Stay until `nco_out_valid`=1, then go to RUN and load the dwell counter.
- **RUN**: `nco_clken`=1.
  - The dwell counter decrements each clken cycle.
  - On the last dwell cycle, compute `nxt` = `nco_phi_inc` + step at APR+1 bits.
  - If `nxt` carries, or `nxt` > stop, or step=0: go to FLUSH.
  - Otherwise set `nco_phi_inc`=`nxt`, increment `step_idx` (SW-bit, wraps) and reload the dwell counter.
- **FLUSH**: `nco_clken`=1 for `NCO_LAT` cycles so the last step drains out of the NCO. Then pulse `done` and go to IDLE.

Sample tagging:
- A delay line `NCO_LAT` deep carries {in_run, `step_idx`} and advances only when `nco_clken`=1.
- `samp_idx` is the delay-line output.
- `samp_valid` = delayed in_run AND `nco_out_valid` AND `nco_clken`.

Pause and abort:
- **pause** (in PRIME, RUN or FLUSH): `nco_clken`=0. Counters, delay line and state all freeze. Resume is seamless with no lost dwell cycle.
- **abort**: next cycle state=IDLE, `nco_clken`=0 and the delay line is cleared. `aborted` pulses and `done` does not.
- **Priority**: abort > pause > start/normal.
- `start` while busy is ignored.

## Timing
- Reset values: `nco_phi_inc`=0, `nco_clken`=0, `busy`=0, `done`=0, `aborted`=0, `step_idx`=0, `samp_valid`=0, `samp_idx`=0. State=IDLE and the delay line is cleared.
- `start` at edge N gives `busy`=1 and `nco_clken`=1 from edge N+1.
- Each step lasts exactly max(`cfg_dwell`,1) unpaused RUN cycles.
- The first tagged sample appears `NCO_LAT` clken cycles after RUN entry.
- `done` is asserted the cycle after the last FLUSH cycle, together with `busy`=0.
- `nxt` == stop is allowed: that step runs and the sweep ends after it.
- `abort` and `start` in the same cycle while in IDLE: abort wins, `aborted` pulses and the sweep does not start.
- Asynchronous reset mid-sweep: all outputs return to reset values immediately.

## Configuration
- Macro `NCO_SWEEP_BIDIR_EN`.
- **Defined**: when the up-sweep reaches its end condition, direction flips and the sweep steps down by step. `step_idx` keeps incrementing. The down-sweep ends when `nxt` < start or borrows, and only then is FLUSH entered.
- **Undefined**: single upward sweep only. No direction register is built.

## Test plan
- **Basic sweep**: start=10, stop=40, step=10, dwell=4 → `nco_phi_inc` = 10,20,30,40 for 4 RUN cycles each, `step_idx` 0..3, `done` one cycle after the 9 FLUSH cycles.
- **Tagging**: same configuration → `samp_valid` first high 9 clken cycles after RUN entry. Exactly 16 samples have `samp_valid`=1 with `samp_idx` 0,0,0,0,1,...,3.
- **Overflow and dwell=0**: start=250, step=4, stop=255, dwell=0 → steps 250 and 254 of one cycle each; 258 carries, so FLUSH follows.
- **Pause**: pause held for 5 cycles mid-step at dwell=8 → `nco_clken`=0 during the pause and the step still receives exactly 8 clken cycles.
- **Abort**: abort during RUN step 2 → IDLE next cycle, `aborted`=1 for 1 cycle, `done` never asserts, `samp_valid`=0. Abort together with start while in IDLE → no sweep.
- **Bidirectional** (`NCO_SWEEP_BIDIR_EN`): start=10, stop=30, step=10, dwell=1 → `nco_phi_inc` 10,20,30,20,10, `step_idx` 0..4, then `done`.
